// File: rtl/mux_sched_pkg.sv
// Shared types and helpers for the mux select scheduler.
// Channel count, select width, FSM states and one-hot decode.
package mux_sched_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } sched_state_t;

    function automatic logic [NCH-1:0] onehot4(input logic [SEL_W-1:0] s);
        onehot4 = 4'b0001 << s;
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Round-robin channel picker: first requester after last_ptr wins.
// The channel at last_ptr itself is searched last.
module rr_next_pick
    import mux_sched_pkg::*;
(
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] last_ptr,
    output logic [SEL_W-1:0] pick,
    output logic             any
);

    logic [SEL_W-1:0] idx;

    // Walk from farthest to nearest so the nearest requester overwrites.
    always_comb begin
        pick = last_ptr;
        idx  = last_ptr;
        any  = |req;
        for (int k = NCH - 1; k >= 0; k--) begin
            idx = last_ptr + SEL_W'(k + 1);
            if (req[idx]) begin
                pick = idx;
            end
        end
    end

endmodule

// File: rtl/mux_sel_scheduler.sv
// Round-robin select generator for the 4:1 data mux.
// Holds each grant for DWELL accepted beats or until the request drops.
module mux_sel_scheduler
    import mux_sched_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   req,
    input  logic             ready,
    output logic [SEL_W-1:0] sel,
    output logic [NCH-1:0]   grant,
    output logic             valid,
    output logic             last_beat
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] DWELL_M1 = CNT_W'(DWELL - 1);

    sched_state_t     state, state_n;
    logic [SEL_W-1:0] sel_n;
    logic [NCH-1:0]   grant_n;
    logic             valid_n;
    logic [CNT_W-1:0] count, count_n;
    logic [SEL_W-1:0] last_ptr, last_ptr_n;

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             accept;
    logic             release_g;

    // While granted, the current channel becomes the pointer on release.
    assign ptr = (state == GRANT) ? sel : last_ptr;

    rr_next_pick u_pick (
        .req      (req),
        .last_ptr (ptr),
        .pick     (pick),
        .any      (any)
    );

    assign accept    = valid && ready;
    assign release_g = (accept && (count == '0)) || !req[sel];
    assign last_beat = valid && (count == '0);

    always_comb begin
        state_n    = state;
        sel_n      = sel;
        grant_n    = grant;
        valid_n    = valid;
        count_n    = count;
        last_ptr_n = last_ptr;
        unique case (state)
            IDLE: begin
                if (any) begin
                    state_n = GRANT;
                    sel_n   = pick;
                    grant_n = onehot4(pick);
                    valid_n = 1'b1;
                    count_n = DWELL_M1;
                end
            end
            GRANT: begin
                if (release_g) begin
                    last_ptr_n = sel;
                    if (any) begin
                        sel_n   = pick;
                        grant_n = onehot4(pick);
                        count_n = DWELL_M1;
                    end else begin
                        state_n = IDLE;
                        grant_n = '0;
                        valid_n = 1'b0;
                    end
                end else if (accept) begin
                    count_n = count - CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            grant    <= '0;
            valid    <= 1'b0;
            count    <= '0;
            last_ptr <= SEL_W'(NCH - 1);
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            grant    <= grant_n;
            valid    <= valid_n;
            count    <= count_n;
            last_ptr <= last_ptr_n;
        end
    end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Directed bench for mux_sel_scheduler (DWELL=4 and DWELL=2 instances).
// Observed word is {sel, grant, valid, last_beat}.
module tb_mux_sel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       ready;

    logic [1:0] sel_a, sel_b;
    logic [3:0] grant_a, grant_b;
    logic       valid_a, valid_b;
    logic       lb_a, lb_b;

    logic [7:0] obs_a, obs_b;
    assign obs_a = {sel_a, grant_a, valid_a, lb_a};
    assign obs_b = {sel_b, grant_b, valid_b, lb_b};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_sel_scheduler #(.DWELL(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
        .sel       (sel_a),
        .grant     (grant_a),
        .valid     (valid_a),
        .last_beat (lb_a)
    );

    mux_sel_scheduler #(.DWELL(2)) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ready     (ready),
        .sel       (sel_b),
        .grant     (grant_b),
        .valid     (valid_b),
        .last_beat (lb_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic [3:0] r);
        rst   = 1'b1;
        req   = r;
        ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset(4'b1111);
        n_checks++;
        if (obs_a !== 8'b00_0000_0_0) begin
            $display("FAIL reset_hold: got %b want %b", obs_a, 8'b00_0000_0_0);
            n_fail++;
        end
        tick();
        n_checks++;
        if (obs_a !== 8'b00_0001_1_0) begin
            $display("FAIL reset_first_grant: got %b want %b", obs_a, 8'b00_0001_1_0);
            n_fail++;
        end
    endtask

    task automatic test_rotation();
        logic [7:0] exp;
        apply_reset(4'b1111);
        tick();
        for (int g = 0; g < 5; g++) begin
            for (int b = 0; b < 4; b++) begin
                exp = {2'(g % 4), 4'(4'b0001 << (g % 4)), 1'b1, (b == 3)};
                n_checks++;
                if (obs_a !== exp) begin
                    $display("FAIL rotation g%0d b%0d: got %b want %b", g, b, obs_a, exp);
                    n_fail++;
                end
                tick();
            end
        end
    endtask

    task automatic test_backpressure();
        logic       rdy [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic       elb [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] exp;
        apply_reset(4'b1100);
        tick();
        n_checks++;
        if (obs_a !== 8'b10_0100_1_0) begin
            $display("FAIL bp_start: got %b want %b", obs_a, 8'b10_0100_1_0);
            n_fail++;
        end
        for (int i = 0; i < 6; i++) begin
            ready = rdy[i];
            tick();
            exp = {2'b10, 4'b0100, 1'b1, elb[i]};
            n_checks++;
            if (obs_a !== exp) begin
                $display("FAIL bp_hold %0d: got %b want %b", i, obs_a, exp);
                n_fail++;
            end
        end
        ready = rdy[6];
        tick();
        n_checks++;
        if (obs_a !== 8'b11_1000_1_0) begin
            $display("FAIL bp_release: got %b want %b", obs_a, 8'b11_1000_1_0);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        apply_reset(4'b1010);
        tick();
        n_checks++;
        if (obs_a !== 8'b01_0010_1_0) begin
            $display("FAIL abort_start: got %b want %b", obs_a, 8'b01_0010_1_0);
            n_fail++;
        end
        tick();
        tick();
        req = 4'b1001;
        tick();
        n_checks++;
        if (obs_a !== 8'b11_1000_1_0) begin
            $display("FAIL abort_next: got %b want %b", obs_a, 8'b11_1000_1_0);
            n_fail++;
        end
        // ch3 dwell ends; pointer now 3 so ch0 follows.
        repeat (4) tick();
        n_checks++;
        if (obs_a !== 8'b00_0001_1_0) begin
            $display("FAIL abort_after: got %b want %b", obs_a, 8'b00_0001_1_0);
            n_fail++;
        end
    endtask

    task automatic test_single_idle();
        logic [7:0] exp;
        apply_reset(4'b0100);
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = {2'b10, 4'b0100, 1'b1, (i % 2 == 1)};
            n_checks++;
            if (obs_b !== exp) begin
                $display("FAIL single %0d: got %b want %b", i, obs_b, exp);
                n_fail++;
            end
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if (obs_b !== 8'b10_0000_0_0) begin
            $display("FAIL idle_drop: got %b want %b", obs_b, 8'b10_0000_0_0);
            n_fail++;
        end
        ready = 1'b0;
        tick();
        n_checks++;
        if (obs_b !== 8'b10_0000_0_0) begin
            $display("FAIL idle_stay: got %b want %b", obs_b, 8'b10_0000_0_0);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(4'b1000);
        tick();
        tick();
        n_checks++;
        if (obs_a !== 8'b11_1000_1_0) begin
            $display("FAIL mid_before: got %b want %b", obs_a, 8'b11_1000_1_0);
            n_fail++;
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (obs_a !== 8'b00_0000_0_0) begin
            $display("FAIL mid_reset: got %b want %b", obs_a, 8'b00_0000_0_0);
            n_fail++;
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (obs_a !== 8'b11_1000_1_0) begin
            $display("FAIL mid_regrant: got %b want %b", obs_a, 8'b11_1000_1_0);
            n_fail++;
        end
        // Full dwell must follow the regrant: last_beat on fourth cycle.
        tick();
        tick();
        tick();
        n_checks++;
        if (obs_a !== 8'b11_1000_1_1) begin
            $display("FAIL mid_last: got %b want %b", obs_a, 8'b11_1000_1_1);
            n_fail++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = 4'b0000;
        ready = 1'b0;
        test_reset();
        test_rotation();
        test_backpressure();
        test_abort();
        test_single_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_scheduler.md
Name: mux_sel_scheduler

Overview:
- Upstream select generator for the 4:1 data mux (mux4x2). It arbitrates four channel request lines round-robin and drives the mux select.
- Each granted channel is held for a programmable number of accepted beats (dwell), or until it withdraws its request.
- A valid/ready handshake with the downstream consumer gates dwell counting.
- All outputs are registered.

Parameters:
- DWELL, 4, accepted beats per grant before rotation; legal range 1..256.
- CNT_W, $clog2(DWELL) with minimum 1, dwell counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  per-channel request; bit i maps to mux input i0..i3.
- ready  input  1  downstream accepts the current mux output this cycle.
- sel  output  2  mux select; sel[1] drives s1, sel[0] drives s0.
- grant  output  4  one-hot of the granted channel; all zero when idle.
- valid  output  1  mux output is meaningful this cycle.
- last_beat  output  1  high on the final dwell beat of the current grant (count==0 while valid).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, sel=2'b00, grant=4'b0000, valid=0, last_beat=0, count=0, last_ptr=3 (so ch0 wins first). Reset has priority over every other event, including mid-grant.
- Round-robin pick: search channels in order last_ptr+1, +2, +3, +4 (mod 4); the first channel with req set wins. The previously granted channel is therefore always lowest priority.
- IDLE state:
  - valid=0 and grant=0; sel holds its last value.
  - If req!=0 at an edge: next state=GRANT, sel/grant=picked channel, valid=1, count=DWELL-1.
  - Latency is one cycle from req sampled to valid high.
- GRANT state:
  - valid=1 and grant=onehot(sel).
  - Beat accepted = valid && ready.
  - Accepted beat with count>0: count decrements.
  - ready=0: count, sel and grant hold; no timeout.
- Release from GRANT (at the edge), either of:
  - (a) accepted beat with count==0 (normal end of dwell);
  - (b) req[sel]==0 (abort; the current cycle's beat still counts if ready=1).
- On release:
  - last_ptr <= sel.
  - If any req is set (the current channel included, at lowest priority), go directly to GRANT on the new pick with count=DWELL-1. There is no idle bubble.
  - Otherwise go to IDLE with valid=0 and grant=0.
- Simultaneous (a) and (b) are treated as one release; no double advance.
- DWELL=1: every accepted beat releases the grant, giving strict per-beat rotation.
- A single requester is re-granted back-to-back with no gap.
- last_beat = valid && (count==0); it is combinationally derived from registered state only, with no input path.
- Counter arithmetic is unsigned CNT_W; it never wraps below 0, because release occurs at 0.
- Req changes on non-granted channels never disturb the current grant.

Decomposition:
- Package mux_sched_pkg:
  - NCH=4, SEL_W=2;
  - typedef enum logic {IDLE, GRANT} sched_state_t;
  - function onehot4(sel) returning logic [3:0].
- Sub-module rr_next_pick: purely combinational; inputs req[3:0] and last_ptr[1:0]; outputs pick[1:0] and any.
- The top module holds the FSM, counter and output registers.

Test Plan:
- Reset with req=4'b1111 held: during rst, valid=0, grant=0, sel=0. One edge after rst deasserts, grant=0001, sel=00, valid=1.
- DWELL=4, req=4'b1111, ready=1: order is ch0,ch1,ch2,ch3,ch0, 4 cycles each; last_beat high on the 4th cycle of each grant; no bubbles.
- Backpressure: ch2 granted, ready toggles 1,0,0,1,1,0,1. Grant releases only after the 4th accepted beat (7 cycles total); sel stays 10 throughout.
- Abort: ch1 granted, req[1] dropped after 2 accepted beats, req=4'b1001 otherwise. Next edge grants ch3 (sel=11), not ch0; last_ptr=1.
- Single requester plus idle: req=4'b0100 only, DWELL=2 gives continuous sel=10 with valid high. Dropping req gives valid=0 and grant=0 one edge later, with sel held at 10.
- Reset mid-grant: rst pulsed while ch3 is granted at count=2. Next edge gives all reset values; with req=4'b1000, ch3 is regranted one edge after rst deasserts.
